// File: rtl/bram_seq_ctrl_if.sv
// Bundle of command, host-write, stream and BRAM signals for bram_seq_ctrl.
//   master : command/host/array/BRAM side (drives start, mode, len, wr_*, out_ready, mem_dout)
//   slave  : the controller (drives wr_ready, out_*, busy, done, mem_we, mem_addr, mem_din)
interface bram_seq_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  start;
    logic                  mode;
    logic [ADDR_WIDTH:0]   len;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output start, mode, len, wr_valid, wr_data, out_ready, mem_dout,
        input  wr_ready, out_valid, out_data, busy, done, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  start, mode, len, wr_valid, wr_data, out_ready, mem_dout,
        output wr_ready, out_valid, out_data, busy, done, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/bram_seq_ctrl.sv
// Sequencer owning a single-port BRAM: LOAD writes len host samples, STREAM
// reads them back in order through a 2-entry skid buffer (valid/ready).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bram_seq_ctrl_if.slave (command, host write, stream out, BRAM port)
module bram_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    bram_seq_ctrl_if.slave bus
);
    localparam int unsigned   CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_pop_cnt;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;

    logic [CW-1:0]         w_len_eff;
    logic                  w_wr_fire;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_issue;
    logic                  w_last_wr;
    logic                  w_last_pop;
    logic                  w_push_slot0;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;

    // Command length saturates at the BRAM depth
    assign w_len_eff  = (bus.len > DEPTH) ? DEPTH : bus.len;

    assign w_wr_fire  = (r_state == S_LOAD) && bus.wr_valid;
    assign w_pop      = (r_occ != 2'd0) && bus.out_ready;
    // Entries the buffer will hold once the in-flight read lands; issue only if a slot stays free
    assign w_level    = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue    = (r_state == S_STREAM) && (r_rd_ptr < r_len) && (w_level < 3'd2);
    assign w_last_wr  = w_wr_fire && (r_wr_ptr == r_len - CW'(1));
    assign w_last_pop = w_pop && (r_pop_cnt == r_len - CW'(1));
    // Returning read goes to the head when the buffer is (or becomes) empty this cycle
    assign w_push_slot0 = (r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop);

    // BRAM address/data hold their last value when idle
    assign w_mem_addr = w_wr_fire ? r_wr_ptr[ADDR_WIDTH-1:0] :
                        w_issue   ? r_rd_ptr[ADDR_WIDTH-1:0] : r_mem_addr;
    assign w_mem_din  = w_wr_fire ? bus.wr_data : r_mem_din;

    assign bus.wr_ready  = (r_state == S_LOAD);
    assign bus.busy      = (r_state == S_LOAD) || (r_state == S_STREAM);
    assign bus.done      = (r_state == S_FIN);
    assign bus.mem_we    = w_wr_fire;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_din   = w_mem_din;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_buf0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_len_eff == CW'(0)) begin
                        w_state_nxt = S_FIN;
                    end else if (bus.mode) begin
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD:   if (w_last_wr)  w_state_nxt = S_FIN;
            S_STREAM: if (w_last_pop) w_state_nxt = S_FIN;
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Pointers, skid buffer and held BRAM port values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pop_cnt  <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_addr <= w_mem_addr;
            r_mem_din  <= w_mem_din;
            r_inflight <= w_issue;
            if ((r_state == S_IDLE) && bus.start) begin
                r_len     <= w_len_eff;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_pop_cnt <= '0;
            end else begin
                if (w_wr_fire) r_wr_ptr  <= r_wr_ptr + CW'(1);
                if (w_issue)   r_rd_ptr  <= r_rd_ptr + CW'(1);
                if (w_pop)     r_pop_cnt <= r_pop_cnt + CW'(1);
            end
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
            if (w_pop) r_buf0 <= r_buf1;
            // Later assignment wins over the shift when the push lands at the head
            if (r_inflight) begin
                if (w_push_slot0) r_buf0 <= bus.mem_dout;
                else              r_buf1 <= bus.mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Self-checking bench for bram_seq_ctrl with a behavioural BRAM and a
// reference memory image; random write gaps, random backpressure and lengths.
module tb_bram_seq_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    logic [DW-1:0] bram_mem [0:DEPTH-1];
    logic [DW-1:0] ref_mem  [0:DEPTH-1];

    bram_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_we) bram_mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= bram_mem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int sat_len(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    // gap_mode: 1 = valid on odd cycles with data 0x11.., 0 = random valid/data
    task automatic do_load(input int n_len, input bit gap_mode, input bit poke);
        int  eff;
        int  wr_cnt;
        int  last_cyc;
        bit  finished;
        eff      = sat_len(n_len);
        wr_cnt   = 0;
        last_cyc = 0;
        finished = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.len = (AW+1)'(n_len); bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc < 300 && !finished; cyc++) begin
            bus.start = poke && (cyc == 2);
            bus.mode  = poke;
            if (wr_cnt < eff) begin
                bus.wr_valid = gap_mode ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
                bus.wr_data  = gap_mode ? DW'(8'h11 + wr_cnt) : DW'($urandom);
            end else begin
                bus.wr_valid = 1'b0;
            end
            @(negedge clk);
            if (wr_cnt < eff) begin
                check_eq("load_wr_ready", bus.wr_ready, 1);
                check_eq("load_busy", bus.busy, 1);
                check_eq("load_done", bus.done, 0);
                check_eq("load_we", bus.mem_we, bus.wr_valid);
                if (bus.wr_valid) begin
                    check_eq("load_addr", bus.mem_addr, wr_cnt);
                    check_eq("load_din", bus.mem_din, bus.wr_data);
                    ref_mem[wr_cnt] = bus.wr_data;
                    wr_cnt++;
                    last_cyc = cyc;
                end
            end else begin
                check_eq("load_done_pulse", bus.done, 1);
                check_eq("load_done_cycle", cyc, last_cyc + 1);
                check_eq("load_fin_busy", bus.busy, 0);
                check_eq("load_fin_we", bus.mem_we, 0);
                check_eq("load_fin_wr_ready", bus.wr_ready, 0);
                finished = 1;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        if (!finished) check_eq("load_timeout", 0, 1);
        @(negedge clk);
        check_eq("load_idle_done", bus.done, 0);
        check_eq("load_idle_busy", bus.busy, 0);
    endtask

    // bp_pct: percentage of cycles with out_ready low
    task automatic do_stream(input int n_len, input int bp_pct);
        int  eff;
        int  idx;
        bit  stalled;
        bit  finished;
        int  last_cyc;
        eff      = sat_len(n_len);
        idx      = 0;
        stalled  = 0;
        finished = 0;
        last_cyc = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 1'b1; bus.len = (AW+1)'(n_len);
        bus.wr_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
            bus.out_ready = ($urandom_range(0, 99) >= bp_pct);
            @(negedge clk);
            if (idx < eff) begin
                check_eq("str_busy", bus.busy, 1);
                check_eq("str_done", bus.done, 0);
                check_eq("str_we", bus.mem_we, 0);
                check_eq("str_wr_ready", bus.wr_ready, 0);
                if (bp_pct == 0) check_eq("str_valid_latency", bus.out_valid, cyc >= 3);
                if (stalled) check_eq("str_valid_held", bus.out_valid, 1);
                if (bus.out_valid) check_eq("str_data", bus.out_data, ref_mem[idx]);
                stalled = bus.out_valid && !bus.out_ready;
                if (bus.out_valid && bus.out_ready) begin
                    idx++;
                    last_cyc = cyc;
                end
            end else begin
                check_eq("str_done_pulse", bus.done, 1);
                check_eq("str_fin_valid", bus.out_valid, 0);
                check_eq("str_fin_busy", bus.busy, 0);
                if (eff == 0) check_eq("str_len0_done_cycle", cyc, 1);
                else          check_eq("str_done_cycle", cyc, last_cyc + 1);
                if (bp_pct == 0 && eff > 0) check_eq("str_full_rate", cyc, eff + 3);
                finished = 1;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        if (!finished) check_eq("stream_timeout", 0, 1);
        check_eq("str_pop_count", idx, eff);
        @(negedge clk);
        check_eq("str_idle_done", bus.done, 0);
        check_eq("str_idle_valid", bus.out_valid, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_wr_ready", bus.wr_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_we", bus.mem_we, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_load(16, 1'b0, 1'b0);
        do_load(5, 1'b1, 1'b0);
        do_stream(16, 0);
        do_stream(8, 50);
        do_load(0, 1'b0, 1'b0);
        do_stream(0, 0);
        do_load(31, 1'b0, 1'b0);
        do_stream(31, 30);
        do_load(6, 1'b1, 1'b1);
        do_stream(6, 0);

        // Reset in the middle of a stream with valid data at the output
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 1'b1; bus.len = 5'd16; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("pre_rst_valid", bus.out_valid, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", bus.out_valid, 0);
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_done", bus.done, 0);
        check_eq("midrst_we", bus.mem_we, 0);
        check_eq("midrst_wr_ready", bus.wr_ready, 0);
        check_eq("midrst_out_data", bus.out_data, 0);
        check_eq("midrst_addr", bus.mem_addr, 0);
        check_eq("midrst_din", bus.mem_din, 0);
        bus.out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_no_done", bus.done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        do_load(3, 1'b0, 1'b0);
        do_stream(3, 0);

        for (int t = 0; t < 8; t++) begin
            do_load($urandom_range(0, 31), 1'b0, 1'($urandom_range(0, 1)));
            do_stream($urandom_range(0, 31), $urandom_range(0, 70));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bram_seq_ctrl.md
# bram_seq_ctrl

Sequencer that owns the single-port `bram` feeding the 1-D convolution systolic array. It runs a host-driven load phase that writes `len` samples into the BRAM, or a stream phase that reads them back in address order and presents them to the array. The stream output uses a valid/ready handshake with backpressure. The BRAM's one-cycle registered read latency is hidden behind a 2-entry skid buffer, so the stream sustains one sample per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 8, sample width; must match the attached `bram`.
- `ADDR_WIDTH`, 4, BRAM address width; depth is 2^ADDR_WIDTH.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `mode` in 1: 0 = LOAD, 1 = STREAM; sampled with `start`.
- `len` in ADDR_WIDTH+1: sample count; sampled with `start`.
- `wr_valid` in 1: host write data valid.
- `wr_data` in DATA_WIDTH: host write data.
- `wr_ready` out 1: controller accepts a host write.
- `out_valid` out 1: stream sample valid.
- `out_data` out DATA_WIDTH: stream sample.
- `out_ready` in 1: array accepts a stream sample.
- `busy` out 1: high in LOAD or STREAM.
- `done` out 1: one-cycle pulse when a command completes.
- `mem_we` out 1: drives `bram.we`.
- `mem_addr` out ADDR_WIDTH: drives `bram.addr`.
- `mem_din` out DATA_WIDTH: drives `bram.din`.
- `mem_dout` in DATA_WIDTH: from `bram.dout`; valid one cycle after the address.

## Operation
States: IDLE, LOAD, STREAM, FIN.

- **IDLE**
  - When `start`=1: latch `mode` and the effective length; go to LOAD or STREAM.
  - Effective length is `len` if `len` ≤ 2^ADDR_WIDTH, otherwise 2^ADDR_WIDTH (saturate).
  - If `len`=0: go to FIN with no memory access.
- **LOAD**
  - `wr_ready`=1.
  - Each cycle with `wr_valid`&&`wr_ready`: `mem_we`=1, `mem_din`=`wr_data`, `mem_addr`=write pointer, pointer increments.
  - After the len-th accepted write, go to FIN.
  - `mem_we` is combinational from `wr_valid` in LOAD and 0 in every other state.
- **STREAM**
  - The read pointer issues address `rd_ptr` on `mem_addr` when (occ + inflight − pop) < 2, and fewer than len reads have been issued.
    - occ = skid-buffer entries (0..2).
    - inflight = 1 if a read was issued in the previous cycle.
    - pop = `out_valid`&&`out_ready`.
  - An issued read increments `rd_ptr`.
  - `mem_dout` is pushed into the skid buffer the cycle after issue.
  - `out_valid`/`out_data` come from the buffer head. Data is stable while `out_valid`=1 and `out_ready`=0.
  - After the len-th pop, go to FIN.
  - When not issuing, `mem_addr` holds its last value. Spurious reads are harmless and are never pushed.
- **FIN**
  - `done`=1 for one cycle; go to IDLE.
- `start` in any state other than IDLE is ignored.
- `busy`=1 in LOAD and STREAM; 0 in IDLE and FIN.
- Pointers count 0..len−1 and never wrap, because len ≤ depth.

## Timing
Reset values (async on `rst_n`=0):
- state = IDLE.
- `wr_ready`, `out_valid`, `busy`, `done`, `mem_we` = 0.
- `mem_addr`, `mem_din`, `out_data`, pointers and skid buffer cleared.

Reset mid-command aborts immediately: no `done`, buffer contents discarded.

Command entry and exit:
- `start` sampled at cycle 0: the new state is active in cycle 1.
- In LOAD, `wr_ready`=1 from cycle 1.
- The last LOAD write or STREAM pop is in cycle t: `done`=1 in cycle t+1; IDLE in t+2, where the next `start` can be taken.
- `len`=0: `done` in cycle 1.

Stream latency and throughput:
- The first read is issued in cycle 1, `mem_dout` is valid in cycle 2, and `out_valid`=1 from cycle 3.
- With `out_ready` held at 1, one sample per cycle is delivered; len samples pop in cycles 3..len+2.
- `out_ready` dropped in cycle k: at most one further read issues; the buffer fills to 2 and issue stalls.
- `out_ready` returned: pops resume the same cycle, with no sample lost or duplicated.

## Test plan
- **Reset:** assert `rst_n`=0 mid-STREAM with `out_valid`=1 → all outputs 0 the same cycle; no `done`; after release, IDLE accepts `start`.
- **LOAD:** mode 0, len 5, host drives 0x11..0x15 with `wr_valid` gapped every other cycle → `mem_we` pulses at addrs 0..4 with matching `mem_din`; `done` one cycle after the 5th write.
- **STREAM, no backpressure:** mode 1, len 16 over the preloaded BRAM, `out_ready`=1 → `out_valid` cycles 3..18, data = mem[0..15] in order, `done` in cycle 19.
- **STREAM, random backpressure:** mode 1, len 8, `out_ready` toggled pseudo-randomly → exactly 8 pops of mem[0..7]; `out_data` stable while stalled; skid occupancy never exceeds 2.
- **Edge lengths:** len=0 → `done` in cycle 1, no `mem_we`, no `out_valid`. len=31 with ADDR_WIDTH=4 → saturates to 16 transfers.
- **start while busy:** pulse `start` mid-LOAD → ignored; the current command completes with a single `done`.
